weight_mem_sequencer: RTL and testbench
=======================================

// Module: weight_mem_sequencer
// PURPOSE
//  Master-side controller for the 30-entry signed-weight memory. It drives that
//  memory's address/write/read/datain pins and consumes its dataout/finish pins.
//  On start it streams DEPTH weights from an upstream valid/ready source into memory.
//  It then reads them back in address order onto a downstream valid/ready port.
//  Finally it probes address DEPTH and checks the memory's finish flag.
// PARAMETERS
//  DEPTH  30  number of weight entries; must satisfy DEPTH < 2**AW
//  DW     9   signed weight width
//  AW     5   memory address width
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   one-cycle pulse; starts load; ignored while busy=1
//  in_valid     in   1   upstream weight valid
//  in_ready     out  1   high only in LOAD
//  in_data      in   DW  signed weight; accepted when in_valid&in_ready
//  mem_address  out  AW  memory address
//  mem_write    out  1   memory write strobe
//  mem_read     out  1   memory read strobe
//  mem_datain   out  DW  memory write data
//  mem_dataout  in   DW  memory read data; valid the cycle after mem_read=1, else 0
//  mem_finish   in   1   memory flag; high the cycle after mem_address==DEPTH
//  out_valid    out  1   readback weight valid
//  out_ready    in   1   downstream accept
//  out_data     out  DW  readback weight
//  out_index    out  AW  address of out_data
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse when a sequence completes
//  err          out  1   sticky: mem_finish was 0 in FIN_WAIT; cleared by the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including mem_address=0 and err=0.
//   Memory contents are not touched. Reset mid-sequence aborts at once; no partial done.
//  IDLE: start -> LOAD, wr_cnt=0, err=0.
//  LOAD: in_ready=1. Each handshake registers mem_write=1, mem_address=wr_cnt and
//   mem_datain=in_data for exactly one cycle, so memory is written one edge later.
//   wr_cnt++. The DEPTH-th handshake -> RD_REQ with rd_cnt=0.
//   Throughput is 1 beat/clk. in_valid=0 stalls indefinitely.
//  RD_REQ (1 clk): mem_read=1, mem_address=rd_cnt -> RD_WAIT.
//  RD_WAIT (1 clk): mem_read=0. out_data<=mem_dataout, out_index<=rd_cnt,
//   out_valid<=1 -> RD_HOLD.
//  RD_HOLD: out_valid/out_data stay stable until out_ready.
//   On handshake: out_valid<=0, rd_cnt++. rd_cnt==DEPTH -> FIN_ADDR, else RD_REQ.
//   Minimum 3 clk per weight. Only one read is ever outstanding.
//  FIN_ADDR (1 clk): mem_address=DEPTH, read=0, write=0 -> FIN_WAIT.
//  FIN_WAIT (1 clk): mem_finish==1 -> done=1. Otherwise done=1 and err<=1.
//   Then mem_address<=0 -> IDLE.
//  mem_write and mem_read are never high together. mem_address is never >DEPTH.
//   In RD_*/LOAD it is never >=DEPTH.
//  Data passes through unmodified, as two's complement (e.g. -256 = 9'h100).
//  start during busy is ignored. start coincident with reset deassertion is ignored.
// STRUCTURE
//  Package weight_mem_pkg: DEPTH/DW/AW localparams and the state enum
//   {IDLE,LOAD,RD_REQ,RD_WAIT,RD_HOLD,FIN_ADDR,FIN_WAIT}.
//  Single module. Counters wr_cnt/rd_cnt and the FSM are kept inline; no sub-module.
//  All outputs are registered or decoded from registered state only.
// TESTING (bench pairs the DUT with the real weight memory model)
//  1. Reset: rst_n=0 mid-LOAD -> all outputs 0 within the same cycle; state IDLE;
//     no done pulse.
//  2. Full load: start, then 30 back-to-back beats 0,1,..,29 (in_valid=1)
//     -> 30 mem_write pulses at addr 0..29; in_ready low from the cycle after beat 30.
//  3. Readback: out_ready=1 constantly -> out_data 0..29 with out_index 0..29,
//     one weight per 3 clk; then done=1 and err=0.
//  4. Backpressure and sign: load -256, 255, -1, ... with out_ready=0 for 5 clk
//     on index 0 -> out_data holds 9'h100 stable; the next mem_read occurs only
//     after the handshake.
//  5. Finish check: force mem_finish=0 during FIN_WAIT -> done=1 and err=1.
//     A following start clears err.
//  6. Upstream gaps: random in_valid gaps and a start pulse while busy
//     -> exactly 30 writes, start ignored, data order preserved.

Source files
------------

// File: rtl/weight_mem_pkg.sv
// Shared sizing and FSM encoding for the weight memory sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package weight_mem_pkg;

  localparam int DEPTH = 30;  // weight entries; must stay below 2**AW
  localparam int DW    = 9;   // signed weight width
  localparam int AW    = 5;   // memory address width

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_REQ,
    RD_WAIT,
    RD_HOLD,
    FIN_ADDR,
    FIN_WAIT
  } state_t;

endpackage

// File: rtl/weight_mem_sequencer.sv
// Loads DEPTH weights into the weight memory, reads them back in order, then probes the finish flag.
// Latency: write lands one edge after the handshake; readback takes 3 clk min per weight, plus 1 clk before the first read.
// Backpressure: in_valid=0 stalls LOAD indefinitely; out_ready=0 holds out_valid/out_data stable in RD_HOLD.
module weight_mem_sequencer
  import weight_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [AW-1:0] mem_address,
  output logic          mem_write,
  output logic          mem_read,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout,
  input  logic          mem_finish,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [DW-1:0] r_datain;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_index;
  logic          r_err;
  logic          r_arm;      // blocks a start sampled on the first edge after reset release

  logic w_start_ok;
  logic w_in_hs;
  logic w_out_hs;
  logic w_rd_issue;

  assign w_start_ok = start & r_arm;
  assign w_in_hs    = (r_state == LOAD) & in_valid;
  assign w_out_hs   = (r_state == RD_HOLD) & r_out_valid & out_ready;
  // The last load beat is still being written during the first RD_REQ cycle;
  // the read waits one cycle so write and read strobes never overlap.
  assign w_rd_issue = (r_state == RD_REQ) & ~r_write;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and outputs decoded from registered state.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    mem_read = w_rd_issue;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (w_in_hs && (r_wr_cnt == LAST_A)) w_next = RD_REQ;
      end
      RD_REQ:   if (w_rd_issue) w_next = RD_WAIT;
      RD_WAIT:  w_next = RD_HOLD;
      RD_HOLD:  if (w_out_hs) w_next = (r_rd_cnt == LAST_A) ? FIN_ADDR : RD_REQ;
      FIN_ADDR: w_next = FIN_WAIT;
      FIN_WAIT: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end

  // Counters, memory-side registers and the readback holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_datain    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_err       <= 1'b0;
      r_arm       <= 1'b0;
    end else begin
      r_arm   <= 1'b1;
      r_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
          end
        end
        LOAD: begin
          if (w_in_hs) begin
            r_write  <= 1'b1;
            r_addr   <= r_wr_cnt;
            r_datain <= in_data;
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (r_wr_cnt == LAST_A) r_rd_cnt <= '0;
          end
        end
        RD_REQ:  r_addr <= r_rd_cnt;
        RD_WAIT: begin
          r_out_data  <= mem_dataout;
          r_out_index <= r_rd_cnt;
          r_out_valid <= 1'b1;
        end
        RD_HOLD: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_rd_cnt    <= r_rd_cnt + 1'b1;
            r_addr      <= (r_rd_cnt == LAST_A) ? DEPTH_A : (r_rd_cnt + 1'b1);
          end
        end
        FIN_WAIT: begin
          if (!mem_finish) r_err <= 1'b1;
          r_addr <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_address = r_addr;
  assign mem_write   = r_write;
  assign mem_datain  = r_datain;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_index   = r_out_index;
  assign err         = r_err;

endmodule

// File: tb/tb_weight_mem_sequencer.sv
// Directed bench for weight_mem_sequencer paired with a behavioural weight memory.
// Latency: n/a.
// Backpressure: bench drives upstream gaps and downstream stalls.
module tb_weight_mem_sequencer;
  import weight_mem_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, mem_write, mem_read, mem_finish, out_valid, busy, done, err;
  logic [AW-1:0] mem_address, out_index;
  logic [DW-1:0] mem_datain, mem_dataout, out_data;

  weight_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout), .mem_finish(mem_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Weight memory model: write on edge, read data the cycle after mem_read, else 0.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] m_dout = '0;
  logic          m_fin = 1'b0;
  logic          fin_kill = 1'b0;
  always @(posedge clk) begin
    if (mem_write && (int'(mem_address) < DEPTH)) mem[mem_address] <= mem_datain;
    m_dout <= mem_read ? mem[mem_address] : '0;
    m_fin  <= (int'(mem_address) == DEPTH);
  end
  assign mem_dataout = m_dout;
  assign mem_finish  = m_fin & ~fin_kill;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation queues and protocol-violation counters.
  int            wq_a[$], wq_d[$], oq_i[$], oq_d[$], oq_c[$];
  int            n_rd = 0, n_done = 0, n_viol = 0;
  logic          p_valid = 1'b0, p_ready = 1'b0;
  logic [DW-1:0] p_data = '0;
  always @(negedge clk) begin
    if (mem_write) begin wq_a.push_back(int'(mem_address)); wq_d.push_back(int'(mem_datain)); end
    if (mem_read) n_rd++;
    if (mem_read && out_valid) n_viol++;
    if (mem_write && mem_read) n_viol++;
    if (int'(mem_address) > DEPTH) n_viol++;
    if (out_valid && p_valid && !p_ready && (out_data !== p_data)) n_viol++;
    if (out_valid && out_ready) begin
      oq_i.push_back(int'(out_index)); oq_d.push_back(int'(out_data)); oq_c.push_back(cyc);
    end
    if (done) n_done++;
    p_valid = out_valid; p_ready = out_ready; p_data = out_data;
  end

  int n_vec = 0, n_bad = 0;
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] vec [DEPTH];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_n(input int n, input int gapmax);
    logic hs;
    int   budget;
    for (int i = 0; i < n; i++) begin
      if (gapmax > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gapmax)) tick();
      end
      in_valid = 1'b1; in_data = vec[i];
      hs = 1'b0; budget = 0;
      while (!hs && budget < 50) begin
        @(negedge clk); hs = in_ready; tick(); budget++;
      end
      if (!hs) begin
        check_eq("in_hs_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 400);
    check_eq("done_seen", done, 1);
    tick();
  endtask

  task automatic clear_q();
    wq_a.delete(); wq_d.delete(); oq_i.delete(); oq_d.delete(); oq_c.delete();
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_nwr"}, wq_a.size(), DEPTH);
    check_eq({tag, "_nrd"}, oq_d.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < wq_a.size(); i++)
      check_eq({tag, "_wr"}, {wq_a[i][15:0], wq_d[i][15:0]}, {16'(i), 7'd0, vec[i]});
    for (int i = 0; i < DEPTH && i < oq_d.size(); i++)
      check_eq({tag, "_rd"}, {oq_i[i][15:0], oq_d[i][15:0]}, {16'(i), 7'd0, vec[i]});
  endtask

  int base, rc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then a start coincident with reset release must be ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", {in_ready, mem_address, mem_write, mem_read, mem_datain, out_valid,
                            out_data, out_index, busy, done, err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b1; tick(); start = 1'b0; tick();
    check_eq("start_at_rst_rel", busy, 0);

    // Reset mid-LOAD clears outputs immediately and produces no done.
    for (int i = 0; i < DEPTH; i++) vec[i] = DW'(i);
    pulse_start();
    send_n(10, 0);
    #2 rst_n = 1'b0; #1;
    check_eq("rst_mid_load", {in_ready, mem_address, mem_write, mem_read, mem_datain, out_valid,
                              out_data, out_index, busy, done, err}, 0);
    repeat (3) tick();
    check_eq("rst_no_done", n_done, 0);
    rst_n = 1'b1; tick(); tick();

    // Full load 0..29 back-to-back, readback with out_ready=1.
    clear_q(); base = n_done; out_ready = 1'b1;
    pulse_start();
    check_eq("busy_after_start", busy, 1);
    send_n(DEPTH, 0);
    @(negedge clk);
    check_eq("in_ready_low_after_last", in_ready, 0);
    wait_done();
    check_eq("err_clean", err, 0);
    check_eq("done_once", n_done - base, 1);
    check_seq("seq_incr");
    for (int i = 1; i < DEPTH && i < oq_c.size(); i++)
      check_eq("rd_interval", oq_c[i] - oq_c[i-1], 3);

    // Signed extremes with a 5-cycle stall on index 0.
    vec[0] = 9'h100; vec[1] = 9'h0FF; vec[2] = 9'h1FF;
    for (int i = 3; i < DEPTH; i++) vec[i] = DW'(i * 37);
    clear_q(); out_ready = 1'b0;
    pulse_start();
    send_n(DEPTH, 0);
    rc = 0;
    while (!out_valid && rc < 20) begin @(negedge clk); rc++; end
    rc = n_rd;
    for (int k = 0; k < 5; k++) begin
      check_eq("hold_data", {out_valid, out_index, out_data}, {1'b1, 5'd0, 9'h100});
      @(negedge clk);
    end
    check_eq("no_read_in_hold", n_rd - rc, 0);
    @(posedge clk); #1; out_ready = 1'b1;
    wait_done();
    check_seq("seq_sign");

    // Finish flag missing -> done with err; next start clears err.
    clear_q(); fin_kill = 1'b1; base = n_done;
    pulse_start();
    send_n(DEPTH, 0);
    wait_done();
    check_eq("err_set", err, 1);
    check_eq("done_on_err", n_done - base, 1);
    fin_kill = 1'b0; clear_q();
    pulse_start();
    check_eq("err_cleared", err, 0);
    send_n(DEPTH, 0);
    wait_done();
    check_eq("err_after_good", err, 0);

    // Random upstream gaps and a start pulse while busy.
    for (int i = 0; i < DEPTH; i++) vec[i] = DW'($urandom);
    clear_q(); base = n_done;
    pulse_start();
    fork
      send_n(DEPTH, 3);
      begin
        repeat (15) @(posedge clk);
        #1 start = 1'b1; @(posedge clk); #1 start = 1'b0;
      end
    join
    wait_done();
    check_seq("seq_gaps");
    repeat (10) tick();
    check_eq("idle_after_gaps", busy, 0);
    check_eq("done_once_gaps", n_done - base, 1);

    check_eq("protocol_viol", n_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
